bsg_link_msg_assembler: RTL

- Core-clock consumer placed directly downstream of the DDR link downstream stage.
- Takes the 64-bit flit stream that stage emits (valid/yumi) and groups flits into multi-flit messages using the header length field.
- Presents each complete message as one wide word on a valid/ready interface to core logic.
- Counts delivered messages.

---
 rtl/bsg_link_msg_assembler.sv | 96 +++++++++
 1 files changed

// File: rtl/bsg_link_msg_assembler.sv
// Groups link flits into multi-flit messages using the header length field and presents
// each one as a wide word. Define BSG_LINK_MSG_ASM_BYPASS_EN to accept the next header in SEND.
module bsg_link_msg_assembler #(
  parameter int flit_width_p = 64,
  parameter int max_flits_p  = 4,
  parameter int len_width_p  = 2
) (
  input  logic                                  core_clk_i,
  input  logic                                  core_link_reset_n_i,
  input  logic [flit_width_p-1:0]               link_data_i,
  input  logic                                  link_v_i,
  output logic                                  link_yumi_o,
  output logic [flit_width_p*max_flits_p-1:0]   msg_data_o,
  output logic [len_width_p-1:0]                msg_len_o,
  output logic                                  msg_v_o,
  input  logic                                  msg_ready_i,
  output logic [15:0]                           msg_count_o
);

  typedef enum logic {RECV = 1'b0, SEND = 1'b1} state_e;

  state_e                                      state;
  logic [len_width_p-1:0]                      idx;
  logic [len_width_p-1:0]                      hdr_len;
  logic [len_width_p-1:0]                      cur_len;
  logic [max_flits_p-1:0][flit_width_p-1:0]    slots;
  logic [15:0]                                 cnt;
  logic                                        take_recv;
  logic                                        take_byp;
  logic                                        deliver;

  assign hdr_len   = link_data_i[len_width_p-1:0];
  // Slot 0 is the header itself, so its length bits are not yet in msg_len_o.
  assign cur_len   = (idx == '0) ? hdr_len : msg_len_o;
  assign deliver   = msg_v_o & msg_ready_i;
  assign take_recv = (state == RECV) & link_v_i;

`ifdef BSG_LINK_MSG_ASM_BYPASS_EN
  assign take_byp  = (state == SEND) & msg_ready_i & link_v_i;
`else
  assign take_byp  = 1'b0;
`endif

  assign link_yumi_o = take_recv | take_byp;
  assign msg_data_o  = slots;
  assign msg_count_o = cnt;

  always_ff @(posedge core_clk_i or negedge core_link_reset_n_i) begin
    if (!core_link_reset_n_i) begin
      state     <= RECV;
      idx       <= '0;
      slots     <= '0;
      msg_len_o <= '0;
      msg_v_o   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        RECV: begin
          if (take_recv) begin
            slots[idx] <= link_data_i;
            if (idx == '0) msg_len_o <= hdr_len;
            if (idx == cur_len) begin
              state   <= SEND;
              msg_v_o <= 1'b1;
              idx     <= '0;
            end else begin
              idx <= idx + len_width_p'(1);
            end
          end
        end
        SEND: begin
          if (deliver) begin
            cnt <= cnt + 16'd1;
            if (take_byp) begin
              // The flit taken alongside the handshake is the next header.
              slots     <= '0;
              slots[0]  <= link_data_i;
              msg_len_o <= hdr_len;
              if (hdr_len != '0) begin
                state   <= RECV;
                msg_v_o <= 1'b0;
                idx     <= len_width_p'(1);
              end
            end else begin
              state   <= RECV;
              msg_v_o <= 1'b0;
              slots   <= '0;
            end
          end
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule
